perf_counter_bank: RTL and testbench

Parametrised, synthesizable successor to the bench-only cycle counter. Holds one free-running cycle counter plus NUM_EVT event counters. All counters are readable and writable through a single-outstanding valid/ready register port. Sits beside the rv32_x core; the core or the testbench reads the counters for benchmark cycle/event statistics and overflow interrupts.

---
 rtl/perf_counter_bank.sv | 142 ++++++++++++++
 tb/tb_perf_counter_bank.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: one free-running cycle counter plus NUM_EVT event counters,
// all readable and writable through a single-outstanding valid/ready register port.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   evt_i[NUM_EVT]        per-cycle event pulses, bit i bumps event counter i
//   req_valid/req_ready   request handshake; req_we, req_addr (word), req_wdata
//   rsp_valid/rsp_ready   response handshake; rsp_rdata (0 for writes/unmapped)
//   irq_o                 registered level interrupt, |(STATUS & IRQ_EN)
// Map: 0 CTRL{CLR,EN}, 1 STATUS (W1C), 2 IRQ_EN, 3/4 cycle lo/hi,
//      5+2i/6+2i event i lo/hi. Hi reads return the shadow captured by the last lo read.
module perf_counter_bank #(
  parameter int unsigned NUM_EVT = 4,
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_rdata,
  output logic               irq_o
);

  localparam int unsigned NUM_CNT    = NUM_EVT + 1;
  localparam int unsigned HI_W       = CNT_W - 32;
  localparam int unsigned A_CTRL     = 0;
  localparam int unsigned A_STATUS   = 1;
  localparam int unsigned A_IRQ_EN   = 2;
  localparam int unsigned A_CNT_BASE = 3;

  // Counter 0 is the cycle counter, counter k>0 is event counter k-1.
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_d;
  logic                          en_q;
  logic [NUM_CNT-1:0]            status_q;
  logic [NUM_CNT-1:0]            irq_en_q;
  logic [HI_W-1:0]               shadow_q;

  logic                          accept_c;
  logic                          wr_c;
  logic                          rd_c;
  logic                          clr_c;
  logic [NUM_CNT-1:0]            inc_c;
  logic [NUM_CNT-1:0]            wrap_c;
  logic [NUM_CNT-1:0]            w1c_c;
  logic [31:0]                   rd_data_c;
  logic                          lo_sel_c;
  logic [HI_W-1:0]               shadow_src_c;

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept_c  = req_valid && req_ready;
  assign wr_c      = accept_c && req_we;
  assign rd_c      = accept_c && !req_we;
  assign clr_c     = wr_c && (req_addr == ADDR_W'(A_CTRL)) && req_wdata[1];
  assign w1c_c     = (wr_c && (req_addr == ADDR_W'(A_STATUS))) ? req_wdata[NUM_CNT-1:0] : '0;
  assign inc_c     = en_q ? {evt_i, 1'b1} : '0;

  // Counter next-state: CLR > register write to a half (drops the increment) > increment.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_c = '0;
    for (int unsigned k = 0; k < NUM_CNT; k++) begin
      if (wr_c && (req_addr == ADDR_W'(A_CNT_BASE + 2 * k))) begin
        cnt_d[k][31:0] = req_wdata;
      end else if (wr_c && (req_addr == ADDR_W'(A_CNT_BASE + 2 * k + 1))) begin
        cnt_d[k][CNT_W-1:32] = req_wdata[HI_W-1:0];
      end else if (inc_c[k]) begin
        cnt_d[k]  = cnt_q[k] + CNT_W'(1);
        wrap_c[k] = &cnt_q[k];
      end
      if (clr_c) begin
        cnt_d[k] = '0;
      end
    end
  end

  // Read mux on pre-edge state; lo reads also select the value to latch into the shadow.
  always_comb begin
    rd_data_c    = '0;
    lo_sel_c     = 1'b0;
    shadow_src_c = '0;
    if (req_addr == ADDR_W'(A_CTRL)) begin
      rd_data_c = {31'd0, en_q};
    end else if (req_addr == ADDR_W'(A_STATUS)) begin
      rd_data_c = 32'(status_q);
    end else if (req_addr == ADDR_W'(A_IRQ_EN)) begin
      rd_data_c = 32'(irq_en_q);
    end
    for (int unsigned k = 0; k < NUM_CNT; k++) begin
      if (req_addr == ADDR_W'(A_CNT_BASE + 2 * k)) begin
        rd_data_c    = cnt_q[k][31:0];
        lo_sel_c     = 1'b1;
        shadow_src_c = cnt_q[k][CNT_W-1:32];
      end else if (req_addr == ADDR_W'(A_CNT_BASE + 2 * k + 1)) begin
        rd_data_c = 32'(shadow_q);
      end
    end
  end

  // State, control registers and response channel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      en_q      <= 1'b0;
      status_q  <= '0;
      irq_en_q  <= '0;
      shadow_q  <= '0;
      irq_o     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      cnt_q    <= cnt_d;
      // A fresh wrap wins over a simultaneous write-1-to-clear.
      status_q <= (status_q & ~w1c_c) | wrap_c;
      irq_o    <= |(status_q & irq_en_q);
      if (wr_c && (req_addr == ADDR_W'(A_CTRL))) begin
        en_q <= req_wdata[0];
      end
      if (wr_c && (req_addr == ADDR_W'(A_IRQ_EN))) begin
        irq_en_q <= req_wdata[NUM_CNT-1:0];
      end
      if (clr_c) begin
        shadow_q <= '0;
      end else if (rd_c && lo_sel_c) begin
        shadow_q <= shadow_src_c;
      end
      if (accept_c) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= req_we ? 32'd0 : rd_data_c;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed self-checking bench for perf_counter_bank (NUM_EVT=4, CNT_W=40).
module tb_perf_counter_bank;

  logic        clk;
  logic        rst_n;
  logic [3:0]  evt_i;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        irq_o;

  int n_cmp;
  int n_fail;

  perf_counter_bank #(.NUM_EVT(4), .CNT_W(40), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .evt_i(evt_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .irq_o(irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bus driver: drive at a negedge, accept on the next posedge, sample one negedge later.
  task automatic do_req(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic [3:0] evt, output logic [31:0] rdata);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; evt_i = evt;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL req_accept addr=%0d: req_ready stuck low, want 1", addr);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; evt_i = '0;
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rsp_latency addr=%0d: rsp_valid=%b want 1", addr, rsp_valid);
    end
    rdata = rsp_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst_n = 1'b0; evt_i = '0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rsp_rdata got %h want 0", rsp_rdata); end
    n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL rst_irq got %b want 0", irq_o); end
    rst_n = 1'b1;
    do_req(1'b0, 8'd3, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL rst_cyc_lo got %h want 0", rd); end
    do_req(1'b0, 8'd9, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL rst_evt2_lo got %h want 0", rd); end
    do_req(1'b0, 8'd1, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL rst_status got %h want 0", rd); end
  endtask

  task automatic test_cycle_count();
    logic [31:0] rd;
    do_req(1'b1, 8'd0, 32'd1, 4'd0, rd);
    n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL wr_rdata got %h want 0", rd); end
    repeat (100) @(negedge clk);
    // EN set at edge P0; read accepted at P102 samples 101 increments (P1..P101).
    do_req(1'b0, 8'd3, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd101) begin n_fail++; $display("FAIL cyc_lo_101 got %0d want 101", rd); end
  endtask

  task automatic test_events();
    logic [31:0] rd;
    repeat (7) begin
      @(negedge clk); evt_i = 4'b0100;
      @(negedge clk); evt_i = 4'b0000;
    end
    do_req(1'b1, 8'd0, 32'd0, 4'd0, rd);
    repeat (5) begin
      @(negedge clk); evt_i = 4'b0100;
      @(negedge clk); evt_i = 4'b0000;
    end
    do_req(1'b0, 8'd9, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd7) begin n_fail++; $display("FAIL evt2_lo got %0d want 7", rd); end
    do_req(1'b0, 8'd10, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL evt2_hi got %h want 0", rd); end
    do_req(1'b0, 8'd0, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL ctrl_en0 got %h want 0", rd); end
  endtask

  task automatic test_coherent();
    logic [31:0] rd;
    do_req(1'b1, 8'd0, 32'd1, 4'd0, rd);
    do_req(1'b1, 8'd4, 32'd0, 4'd0, rd);
    do_req(1'b1, 8'd3, 32'hFFFF_FFFE, 4'd0, rd);
    repeat (4) @(negedge clk);
    // 5 increments after the lo write before the read's accept edge.
    do_req(1'b0, 8'd3, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd3) begin n_fail++; $display("FAIL carry_lo got %h want 3", rd); end
    do_req(1'b0, 8'd4, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd1) begin n_fail++; $display("FAIL carry_hi got %h want 1", rd); end
    do_req(1'b1, 8'd4, 32'h22, 4'd0, rd);
    do_req(1'b0, 8'd4, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd1) begin n_fail++; $display("FAIL stale_shadow got %h want 1", rd); end
    do_req(1'b0, 8'd3, 32'd0, 4'd0, rd);
    do_req(1'b0, 8'd4, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'h22) begin n_fail++; $display("FAIL hi_write got %h want 22", rd); end
  endtask

  task automatic test_overflow_irq();
    logic [31:0] rd;
    do_req(1'b1, 8'd2, 32'd1, 4'd0, rd);
    do_req(1'b1, 8'd4, 32'hFF, 4'd0, rd);
    do_req(1'b1, 8'd3, 32'hFFFF_FFF0, 4'd0, rd);
    // Wrap lands on the 16th increment; irq_o follows one edge later.
    repeat (16) @(negedge clk);
    n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_early got %b want 0", irq_o); end
    @(negedge clk);
    n_cmp++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_assert got %b want 1", irq_o); end
    do_req(1'b0, 8'd1, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd1) begin n_fail++; $display("FAIL status_wrap got %h want 1", rd); end
    do_req(1'b0, 8'd3, 32'd0, 4'd0, rd);
    do_req(1'b0, 8'd4, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL wrap_hi got %h want 0", rd); end
    do_req(1'b1, 8'd1, 32'd1, 4'd0, rd);
    n_cmp++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_hold got %b want 1", irq_o); end
    @(negedge clk);
    n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b want 0", irq_o); end
    do_req(1'b0, 8'd1, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL status_w1c got %h want 0", rd); end
  endtask

  task automatic test_collisions();
    logic [31:0] rd;
    do_req(1'b1, 8'd5, 32'h10, 4'b0001, rd);
    do_req(1'b0, 8'd5, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'h10) begin n_fail++; $display("FAIL wr_vs_inc got %h want 10", rd); end
    do_req(1'b1, 8'd8, 32'hFF, 4'd0, rd);
    do_req(1'b1, 8'd7, 32'hFFFF_FFFF, 4'd0, rd);
    do_req(1'b1, 8'd0, 32'd3, 4'b0010, rd);
    // CLR at edge Pc; read accepted at Pc+2 sees exactly one increment.
    do_req(1'b0, 8'd3, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd1) begin n_fail++; $display("FAIL clr_cyc_lo got %0d want 1", rd); end
    do_req(1'b0, 8'd7, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL clr_evt1_lo got %h want 0", rd); end
    do_req(1'b0, 8'd8, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL clr_evt1_hi got %h want 0", rd); end
    do_req(1'b0, 8'd9, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL clr_evt2_lo got %h want 0", rd); end
    do_req(1'b0, 8'd1, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd4) begin n_fail++; $display("FAIL clr_status got %h want 4", rd); end
    do_req(1'b0, 8'd0, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd1) begin n_fail++; $display("FAIL ctrl_after_clr got %h want 1", rd); end
    n_cmp++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_masked got %b want 0", irq_o); end
    do_req(1'b0, 8'd200, 32'd0, 4'd0, rd);
    n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL unmapped got %h want 0", rd); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_rsp_valid got %b want 0", rsp_valid); end
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd1; req_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    req_addr = 8'd2;
    repeat (5) begin
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready got %b want 0", req_ready); end
      n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_valid got %b want 1", rsp_valid); end
      n_cmp++; if (rsp_rdata !== 32'd4) begin n_fail++; $display("FAIL bp_rsp_rdata got %h want 4", rsp_rdata); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid1 got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'd1) begin n_fail++; $display("FAIL b2b_rdata1 got %h want 1", rsp_rdata); end
    req_addr = 8'd1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid2 got %b want 1", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'd4) begin n_fail++; $display("FAIL b2b_rdata2 got %h want 4", rsp_rdata); end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", rsp_valid); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_cycle_count();
    test_events();
    test_coherent();
    test_overflow_irq();
    test_collisions();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
